radix16_ifft: RTL
=================

# radix16_ifft

Serial inverse of the radix-16 shift-based transform used in the MMH-MH privacy-amplification datapath. The block accepts one 16-word spectral block over a valid/ready stream, computes the 16-point inverse Fermat-number transform modulo M = 2^64+1 with the 1/16 scale folded in, and streams the 16 time-domain words back out. It sits after the forward transform and pointwise stage, returning spectra to residue form.

## Interface
- DATA_WIDTH, 64, residue exponent; M = 2^DATA_WIDTH + 1; only 64 is supported.
- RADIX, 16, points per block; fixed.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a spectral word.
- in_data  in  DATA_WIDTH+1  spectral word X_k, k = arrival order 0..15.
- out_valid  out  1  out_data holds a result word.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_WIDTH+1  time-domain word x_j, j = 0..15 in order.
- out_last  out  1  high with out_valid for x_15.
- busy  out  1  high in CALC or EMIT.

## Operation
- Arithmetic: x_j = sum over k of X_k * 2^s(j,k) mod M, with s(j,k) = (124 - 8*((j*k) mod 16)) mod 128. ω = 2^8 has order 16; 2^124 = 2^-8jk * 16^-1 fold.
- Residues are in [0, 2^64], 65 bits. Input sanitising: if in_data[64] = 1, the word is taken as 2^64 and the low bits are ignored.
- Term multiply: r = X * 2^(s mod 64) split into lo = bits[63:0] and hi = upper bits; t = lo - hi, add M if negative. If s >= 64, negate: t = M - t when t != 0. Accumulate: acc = acc + t, subtract M if acc >= M. Accumulator is 66 bits before reduction.
- Buffer: 16 x 65-bit register file, written in LOAD, read in CALC.
- FSM:
  - LOAD: in_ready = 1; each in_valid&&in_ready writes buf[kin], kin++. On the 16th accept go to CALC, j = 0, k = 0, acc = 0.
  - CALC: one term per cycle, k = 0..15. After k = 15 go to EMIT with out_data = final acc.
  - EMIT: out_valid = 1, out_data and out_last stable until out_ready. On accept: if j < 15 then j++, k = 0, acc = 0, go to CALC. Otherwise go to LOAD and set kin = 0.
- in_ready = 0 in CALC and EMIT. Input is ignored there regardless of in_valid.
- Reset at any time (asynchronous) returns to LOAD, discards the partial block, clears all counters.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
- in_ready is a registered state decode. It falls on the edge that accepts the 16th word.
- First out_valid rises 17 cycles after the edge accepting the 16th word (1 state entry + 16 term cycles).
- With out_ready held high, outputs are spaced 17 cycles apart. Block throughput is 16 load + 16 × 17 = 288 cycles minimum.
- Backpressure: out_valid never drops without acceptance, and out_data does not change while out_valid && !out_ready.
- After x_15 is accepted, in_ready = 1 on the next cycle.
- Gaps in in_valid stall LOAD without penalty. kin holds its value.

## Test plan
- X_0 = 16, others 0 → all 16 x_j = 1; out_last only on the 16th.
- All X_k = 16 → x_0 = 16, x_1..x_15 = 0.
- X_0 = 2^64 (in_data = 0x1_0000_0000_0000_0000), others 0 → all x_j = 0x0_1000_0000_0000_0000.
- X_1 = 16, others 0 → x_0 = 1, x_1 = 0x0_FF00_0000_0000_0001, x_8 = 0x1_0000_0000_0000_0000.
- Random blocks with random in_valid gaps and random out_ready stalls → outputs match the software inverse. Each output equals the forward transform's input after round trip. out_data is stable under stall. First out_valid is exactly 17 cycles after the last accept when out_ready = 1.
- Assert rst low mid-CALC, after 5 of 16 outputs → all outputs return to reset values immediately. A following clean block produces correct results from j = 0.

Source files
------------

// File: rtl/radix16_ifft.sv
// radix16_ifft: serial 16-point inverse Fermat-number transform modulo 2^64+1.
// Loads a 16-word spectral block, evaluates one output word per 17-cycle
// CALC pass (1 pipeline fill + 16 terms) and streams the words out in order.
module radix16_ifft #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RADIX      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned XW = DATA_WIDTH + 1;
    localparam int unsigned IW = $clog2(RADIX);

    // Modulus 2^W + 1 and the residue 2^W
    localparam logic [W:0] MOD   = {1'b1, {(W - 1){1'b0}}, 1'b1};
    localparam logic [W:0] TWO_W = {1'b1, {W{1'b0}}};

    // 2^124 = 16^-1 mod M; each j*k step removes one factor of omega = 2^8
    localparam logic [6:0] SHIFT_BASE = 7'd124;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CALC,
        ST_EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   kin_q, kin_d;
    logic [IW-1:0]   j_q, j_d;
    logic [IW:0]     cnt_q, cnt_d;
    logic [W:0]      acc_q, acc_d;
    logic [W:0]      term_q, term_d;
    logic [W:0]      out_data_q, out_data_d;
    logic [W:0]      buf_q [RADIX];
    logic [W:0]      buf_d [RADIX];

    logic [W:0]      in_word;
    logic [W:0]      x_sel;
    logic [IW-1:0]   m;
    logic [6:0]      s;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    lo;
    logic [W-1:0]    hi;
    logic [W:0]      t_sub;
    logic [W:0]      term_new;
    logic [W+1:0]    acc_sum;
    logic [W:0]      acc_next;

    // Sanitise input: a set top bit means the residue 2^64, low bits ignored
    always_comb begin
        in_word = in_data[W] ? TWO_W : in_data;
    end

    // Term X_k * 2^s(j,k) mod M, folded as lo - hi with a sign flip for s >= 64
    always_comb begin
        x_sel = buf_q[cnt_q[IW-1:0]];
        m     = IW'(j_q * cnt_q[IW-1:0]);
        s     = SHIFT_BASE - {m, 3'b000};
        prod  = {{(W - 1){1'b0}}, x_sel} << s[5:0];
        lo    = prod[W-1:0];
        hi    = prod[2*W-1:W];
        if (lo >= hi) begin
            t_sub = {1'b0, lo - hi};
        end else begin
            t_sub = {1'b0, lo} + MOD - {1'b0, hi};
        end
        if (s[6] && (t_sub != '0)) begin
            term_new = MOD - t_sub;
        end else begin
            term_new = t_sub;
        end
    end

    // Modular accumulate of the registered term; one subtract suffices as both are < M
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, term_q};
        acc_next = XW'((acc_sum >= {1'b0, MOD}) ? (acc_sum - {1'b0, MOD}) : acc_sum);
    end

    // FSM next state, counters, buffer writes and output word capture
    always_comb begin
        state_d    = state_q;
        kin_d      = kin_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        term_d     = term_q;
        out_data_d = out_data_q;
        buf_d      = buf_q;
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    buf_d[kin_q] = in_word;
                    kin_d        = kin_q + IW'(1);
                    if (kin_q == IW'(RADIX - 1)) begin
                        state_d = ST_CALC;
                        j_d     = '0;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
            end
            ST_CALC: begin
                // cnt 0 only fills term_q; cnt 1..16 add terms k = 0..15
                term_d = term_new;
                cnt_d  = cnt_q + (IW + 1)'(1);
                if (cnt_q != '0) begin
                    acc_d = acc_next;
                end
                if (cnt_q == (IW + 1)'(RADIX)) begin
                    state_d    = ST_EMIT;
                    out_data_d = acc_next;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (j_q != IW'(RADIX - 1)) begin
                        j_d     = j_q + IW'(1);
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_LOAD;
                        kin_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOAD;
            kin_q      <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            term_q     <= '0;
            out_data_q <= '0;
            for (int unsigned i = 0; i < RADIX; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            kin_q      <= kin_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            term_q     <= term_d;
            out_data_q <= out_data_d;
            buf_q      <= buf_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = (state_q == ST_EMIT) && (j_q == IW'(RADIX - 1));
    assign busy      = (state_q != ST_LOAD);
    assign out_data  = out_data_q;

endmodule
